// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction descriptors (opcode, registers,
// funct fields, immediate) into 32-bit words and streams them into
// instruction memory at sequential, wrapping word addresses.
//
// Optional feature macro: INSTR_ENCODER_IMM_CHECK_EN
//   defined   -> immediates are range/alignment checked per format and
//                out-of-range descriptors are dropped with o_err raised.
//   undefined -> immediates are silently truncated to the format's fields.
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MEM_BYTES = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [6:0]        i_opcode,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    output logic              o_mem_we,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_err_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Addresses live inside a power-of-two imem window and are word aligned.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_idx_q, err_idx_d;

    logic [31:0] enc_word;
    logic        enc_valid;
    logic        imm_ok;
    logic        accept;
    logic        wr_hs;
    logic        load;
    logic        drop;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    // An immediate fits N signed bits when all bits above N-1 equal the sign.
    logic fits_12;
    logic fits_13;
    logic fits_21;
    assign fits_12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign fits_13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign fits_21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);
`endif

    // Format selection and bit packing for the descriptor currently presented.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        enc_word  = 32'd0;
        enc_valid = 1'b0;
        imm_ok    = 1'b1;
        case (i_opcode)
            OP_R: begin
                enc_word  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                enc_valid = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                enc_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_valid = 1'b1;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                imm_ok    = fits_12;
`endif
            end
            OP_STORE: begin
                enc_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_valid = 1'b1;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                imm_ok    = fits_12;
`endif
            end
            OP_BRANCH: begin
                enc_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                enc_valid = 1'b1;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                imm_ok    = fits_13 & ~i_imm[0];
`endif
            end
            OP_LUI, OP_AUIPC: begin
                enc_word  = {i_imm[31:12], i_rd, i_opcode};
                enc_valid = 1'b1;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                imm_ok    = ~(|i_imm[11:0]);
`endif
            end
            OP_JAL: begin
                enc_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                enc_valid = 1'b1;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
                imm_ok    = fits_21 & ~i_imm[0];
`endif
            end
            default: begin
                enc_word  = 32'd0;
                enc_valid = 1'b0;
            end
        endcase
    end

    // A new descriptor may enter when the single output register is free or draining this cycle.
    assign o_ready = (state_q == S_RUN) && (rem_q != '0) && (!we_q || i_mem_ready);
    assign accept  = i_valid & o_ready;
    assign wr_hs   = we_q & i_mem_ready;
    assign load    = accept & enc_valid & imm_ok;
    assign drop    = accept & ~(enc_valid & imm_ok);

    // Batch sequencing, output register update and error bookkeeping.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    if (i_count != '0) begin
                        state_d = S_RUN;
                        addr_d  = i_base_addr & ADDR_MASK & WORD_MASK;
                        rem_d   = i_count;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (wr_hs) begin
                    we_d   = 1'b0;
                    addr_d = (addr_q + ADDR_W'(4)) & ADDR_MASK;
                end
                // A load in the same cycle as a handshake refills the register with no bubble.
                if (load) begin
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                end
                if (accept) begin
                    rem_d = rem_q - CNT_W'(1);
                    idx_d = idx_q + CNT_W'(1);
                end
                if (drop) begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        err_idx_d = idx_q;
                    end
                end
                if ((rem_d == '0) && !we_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any batch in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_err       = err_q;
    assign o_err_idx   = err_idx_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: reset, basic R/I/S encoding,
// B/J/U encoding, backpressure with address wrap, error handling,
// optional immediate check, zero-count batch, ignored restart and
// reset in the middle of a batch.
module tb_instr_encoder;

    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 16;
    localparam int MEM_BYTES = 4096;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [CNT_W-1:0]  i_count;
    logic              i_valid;
    logic              o_ready;
    logic [6:0]        i_opcode;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic [31:0]       i_imm;
    logic              o_mem_we;
    logic              i_mem_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [CNT_W-1:0]  o_err_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    int          cyc         = 0;
    int          last_hs_cyc = 0;
    int          done_cyc    = 0;
    int          done_cnt    = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    instr_encoder #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_count    (i_count),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_opcode   (i_opcode),
        .i_rd       (i_rd),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_funct3   (i_funct3),
        .i_funct7   (i_funct7),
        .i_imm      (i_imm),
        .o_mem_we   (o_mem_we),
        .i_mem_ready(i_mem_ready),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_idx  (o_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write handshake and every done pulse at the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && o_mem_we && i_mem_ready) begin
            wr_addr.push_back(o_mem_addr);
            wr_data.push_back(o_mem_wdata);
            last_hs_cyc <= cyc;
        end
        if (rst_n && o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic start_batch(input logic [31:0] base, input logic [15:0] count);
        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = base;
        i_count     = count;
        @(negedge clk);
        i_start     = 1'b0;
    endtask

    // Present one descriptor and hold it until accepted; returns right after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        bit got = 1'b0;
        @(negedge clk);
        i_valid  = 1'b1;
        i_opcode = op;
        i_rd     = rd;
        i_rs1    = rs1;
        i_rs2    = rs2;
        i_funct3 = f3;
        i_funct7 = f7;
        i_imm    = imm;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (o_ready) begin
                @(posedge clk);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_accept_timeout op=%b got no o_ready, required acceptance", op);
        end
    endtask

    task automatic idle_valid();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_done_timeout got no o_done, required a pulse", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({o_mem_we, o_busy, o_done, o_err, o_ready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got we/busy/done/err/ready=%b required 00000",
                     {o_mem_we, o_busy, o_done, o_err, o_ready});
        end
        tests_run++;
        if (o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0 || o_err_idx !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_regs got addr=%h wdata=%h err_idx=%0d required all 0",
                     o_mem_addr, o_mem_wdata, o_err_idx);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_a[3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] exp_d[3] = '{32'h00500093, 32'h002081B3, 32'h0020A423};
        int d0 = done_cnt;
        clear_log();
        start_batch(32'h100, 16'd3);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);   // addi x1,x0,5
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);   // add x3,x1,x2
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);   // sw x2,8(x1)
        idle_valid();
        wait_done("basic", d0);
        tests_run++;
        if (wr_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL basic_count got %0d writes required 3", wr_addr.size());
        end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            tests_run++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL basic_write[%0d] got %h@%h required %h@%h",
                         i, wr_data[i], wr_addr[i], exp_d[i], exp_a[i]);
            end
        end
        tests_run++;
        if (done_cyc !== last_hs_cyc + 1) begin
            tests_failed++;
            $display("FAIL basic_done_timing got done at %0d required %0d", done_cyc, last_hs_cyc + 1);
        end
        #1;
        tests_run++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_after_done got done=%b busy=%b required 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_bju();
        logic [31:0] exp_d[3] = '{32'h00208463, 32'h010000EF, 32'h123452B7};
        int d0 = done_cnt;
        clear_log();
        start_batch(32'h20, 16'd3);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8);            // beq x1,x2,+8
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd16);           // jal x1,+16
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000);     // lui x5
        idle_valid();
        wait_done("bju", d0);
        tests_run++;
        if (wr_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL bju_count got %0d writes required 3", wr_addr.size());
        end
        for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
            tests_run++;
            if (wr_data[i] !== exp_d[i] || wr_addr[i] !== 32'h20 + 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL bju_write[%0d] got %h@%h required %h@%h",
                         i, wr_data[i], wr_addr[i], exp_d[i], 32'h20 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure_wrap();
        int d0 = done_cnt;
        clear_log();
        start_batch(32'hFFC, 16'd2);
        i_mem_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);   // addi x1,x0,5
        @(negedge clk);
        i_opcode = 7'b0110011;                                      // add x3,x1,x2
        i_rd     = 5'd3;
        i_rs1    = 5'd1;
        i_rs2    = 5'd2;
        i_funct3 = 3'b000;
        i_funct7 = 7'd0;
        i_imm    = 32'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (o_mem_we !== 1'b1 || o_mem_addr !== 32'hFFC || o_mem_wdata !== 32'h00500093
                || o_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall[%0d] got we=%b addr=%h wdata=%h ready=%b required 1 ffc 00500093 0",
                         k, o_mem_we, o_mem_addr, o_mem_wdata, o_ready);
            end
            @(negedge clk);
        end
        i_mem_ready = 1'b1;
        #1;
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready got %b required 1", o_ready);
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        tests_run++;
        if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h002081B3) begin
            tests_failed++;
            $display("FAIL wrap_reload got we=%b addr=%h wdata=%h required 1 00000000 002081b3",
                     o_mem_we, o_mem_addr, o_mem_wdata);
        end
        wait_done("wrap", d0);
        tests_run++;
        if (wr_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL wrap_count got %0d writes required 2", wr_addr.size());
        end else begin
            tests_run++;
            if (wr_addr[0] !== 32'hFFC || wr_addr[1] !== 32'h0 || wr_data[0] !== 32'h00500093
                || wr_data[1] !== 32'h002081B3) begin
                tests_failed++;
                $display("FAIL wrap_writes got %h@%h %h@%h required 00500093@ffc 002081b3@0",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_errors();
        int d0 = done_cnt;
        clear_log();
        start_batch(32'h300, 16'd3);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);   // addi x1,x0,1
        send(7'h7F,      5'd1, 5'd2, 5'd3, 3'b000, 7'd0, 32'd0);   // unsupported
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);   // add x3,x1,x2
        idle_valid();
        wait_done("err", d0);
        tests_run++;
        if (wr_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL err_count got %0d writes required 2", wr_addr.size());
        end else begin
            tests_run++;
            if (wr_addr[0] !== 32'h300 || wr_data[0] !== 32'h00100093
                || wr_addr[1] !== 32'h304 || wr_data[1] !== 32'h002081B3) begin
                tests_failed++;
                $display("FAIL err_writes got %h@%h %h@%h required 00100093@300 002081b3@304",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
        tests_run++;
        if (o_err !== 1'b1 || o_err_idx !== 16'd1) begin
            tests_failed++;
            $display("FAIL err_flag got err=%b idx=%0d required 1 1", o_err, o_err_idx);
        end
    endtask

    task automatic test_imm_check();
        int d0 = done_cnt;
        clear_log();
        start_batch(32'h500, 16'd1);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096);   // addi x1,x0,4096
        idle_valid();
        wait_done("imm", d0);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        tests_run++;
        if (wr_addr.size() !== 0 || o_err !== 1'b1 || o_err_idx !== 16'd0) begin
            tests_failed++;
            $display("FAIL imm_dropped got writes=%0d err=%b idx=%0d required 0 1 0",
                     wr_addr.size(), o_err, o_err_idx);
        end
`else
        tests_run++;
        if (wr_addr.size() !== 1 || o_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL imm_truncate_count got writes=%0d err=%b required 1 0", wr_addr.size(), o_err);
        end else begin
            tests_run++;
            if (wr_data[0] !== 32'h00000093 || wr_addr[0] !== 32'h500) begin
                tests_failed++;
                $display("FAIL imm_truncate_word got %h@%h required 00000093@500", wr_data[0], wr_addr[0]);
            end
        end
`endif
    endtask

    task automatic test_zero_count();
        int d0 = done_cnt;
        clear_log();
        start_batch(32'h700, 16'd0);
        #1;
        tests_run++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done got done=%b busy=%b we=%b required 1 1 0", o_done, o_busy, o_mem_we);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || done_cnt !== d0 + 1 || wr_addr.size() !== 0) begin
            tests_failed++;
            $display("FAIL zero_after got done=%b busy=%b pulses=%0d writes=%0d required 0 0 1 0",
                     o_done, o_busy, done_cnt - d0, wr_addr.size());
        end
        tests_run++;
        if (o_err !== 1'b0 || o_err_idx !== 16'd0) begin
            tests_failed++;
            $display("FAIL zero_err_clear got err=%b idx=%0d required 0 0", o_err, o_err_idx);
        end
    endtask

    task automatic test_start_ignored();
        int d0 = done_cnt;
        clear_log();
        start_batch(32'h200, 16'd2);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000);  // lui x5
        idle_valid();
        start_batch(32'h300, 16'd5);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);         // addi x1,x0,5
        idle_valid();
        wait_done("restart", d0);
        repeat (4) @(negedge clk);
        tests_run++;
        if (wr_addr.size() !== 2 || o_busy !== 1'b0 || done_cnt !== d0 + 1) begin
            tests_failed++;
            $display("FAIL restart_count got writes=%0d busy=%b pulses=%0d required 2 0 1",
                     wr_addr.size(), o_busy, done_cnt - d0);
        end else begin
            tests_run++;
            if (wr_addr[0] !== 32'h200 || wr_data[0] !== 32'h123452B7
                || wr_addr[1] !== 32'h204 || wr_data[1] !== 32'h00500093) begin
                tests_failed++;
                $display("FAIL restart_writes got %h@%h %h@%h required 123452b7@200 00500093@204",
                         wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int d0;
        clear_log();
        start_batch(32'h80, 16'd3);
        send(7'h7F, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0);           // unsupported, raises o_err
        i_mem_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);      // held in output register
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        tests_run++;
        if (o_err !== 1'b1 || o_mem_we !== 1'b1 || o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_pre got err=%b we=%b busy=%b required 1 1 1", o_err, o_mem_we, o_busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_mem_we, o_busy, o_err, o_done, o_ready} !== 5'b0 || o_mem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset got we/busy/err/done/ready=%b addr=%h required 00000 0",
                     {o_mem_we, o_busy, o_err, o_done, o_ready}, o_mem_addr);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        i_mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (o_mem_addr !== 32'd0 || o_busy !== 1'b0 || wr_addr.size() !== 0) begin
            tests_failed++;
            $display("FAIL midrun_idle got addr=%h busy=%b writes=%0d required 0 0 0",
                     o_mem_addr, o_busy, wr_addr.size());
        end
        d0 = done_cnt;
        start_batch(32'h40, 16'd1);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        idle_valid();
        wait_done("midrun", d0);
        tests_run++;
        if (wr_addr.size() !== 1) begin
            tests_failed++;
            $display("FAIL midrun_restart_count got %0d writes required 1", wr_addr.size());
        end else begin
            tests_run++;
            if (wr_addr[0] !== 32'h40 || wr_data[0] !== 32'h00500093) begin
                tests_failed++;
                $display("FAIL midrun_restart_write got %h@%h required 00500093@40", wr_data[0], wr_addr[0]);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_count     = '0;
        i_valid     = 1'b0;
        i_opcode    = '0;
        i_rd        = '0;
        i_rs1       = '0;
        i_rs2       = '0;
        i_funct3    = '0;
        i_funct7    = '0;
        i_imm       = '0;
        i_mem_ready = 1'b1;

        test_reset();
        test_basic();
        test_bju();
        test_backpressure_wrap();
        test_errors();
        test_zero_count();
        test_imm_check();
        test_start_ignored();
        test_reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
